// File: rtl/sr04_echo_emulator_if.sv
// Trigger/echo link between a distance controller
// and the sensor end (emulator).
interface sr04_echo_emulator_if;
  logic       i_trigger;
  logic [8:0] i_dist_cm;
  logic       o_echo;
  logic       o_busy;
  logic [7:0] o_trig_cnt;

  modport master (
    output i_trigger,
    output i_dist_cm,
    input  o_echo,
    input  o_busy,
    input  o_trig_cnt
  );

  modport slave (
    input  i_trigger,
    input  i_dist_cm,
    output o_echo,
    output o_busy,
    output o_trig_cnt
  );
endinterface

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 sensor-end model: accepts a trigger pulse and
// answers with an echo whose width encodes a distance.
module sr04_echo_emulator #(
  parameter int CLK_DIV       = 100,
  parameter int TRIG_MIN_US   = 10,
  parameter int ECHO_DELAY_US = 200,
  parameter int US_PER_CM     = 58,
  parameter int MAX_CM        = 400,
  parameter int TIMEOUT_US    = 38000,
  parameter int COOLDOWN_US   = 10000
) (
  input  logic                 clk,
  input  logic                 rst,
  sr04_echo_emulator_if.slave  bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_BURST,
    S_ECHO,
    S_COOL
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_trig_d;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_us;
  logic [15:0]   r_len;
  logic          r_echo;
  logic          r_busy;
  logic [7:0]    r_cnt;

  logic          w_tick;
  logic          w_rise;
  logic          w_oor;
  logic [15:0]   w_us_nxt;
  logic [15:0]   w_prod;
  logic [15:0]   w_len;

  assign w_tick = (r_pre == PW'(CLK_DIV - 1));
  assign w_rise = r_sync2 & ~r_trig_d;

  // us count including the current cycle; saturates
  assign w_us_nxt = (w_tick && r_us != 16'hFFFF)
                  ? r_us + 16'd1 : r_us;

  assign w_prod = 16'(bus.i_dist_cm) * 16'(US_PER_CM);
  assign w_oor  = (bus.i_dist_cm == 9'd0)
               || (16'(bus.i_dist_cm) > 16'(MAX_CM));
  assign w_len  = w_oor ? 16'(TIMEOUT_US) : w_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_trig_d <= 1'b0;
      r_pre    <= '0;
      r_us     <= '0;
      r_len    <= '0;
      r_echo   <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= bus.i_trigger;
      r_sync2  <= r_sync1;
      r_trig_d <= r_sync2;
      r_pre    <= w_tick ? '0 : r_pre + PW'(1);
      r_us     <= w_us_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_TRIG;
            r_busy  <= 1'b1;
            r_pre   <= '0;
            r_us    <= '0;
          end
        end
        S_TRIG: begin
          if (!r_sync2) begin
            r_pre <= '0;
            r_us  <= '0;
            if (w_us_nxt >= 16'(TRIG_MIN_US)) begin
              r_state <= S_BURST;
              r_len   <= w_len;
              r_cnt   <= r_cnt + 8'd1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_BURST: begin
          if (w_tick && w_us_nxt == 16'(ECHO_DELAY_US)) begin
            r_state <= S_ECHO;
            r_echo  <= 1'b1;
            r_pre   <= '0;
            r_us    <= '0;
          end
        end
        S_ECHO: begin
          if (w_tick && w_us_nxt == r_len) begin
            r_state <= S_COOL;
            r_echo  <= 1'b0;
            r_pre   <= '0;
            r_us    <= '0;
          end
        end
        S_COOL: begin
          if (w_tick && w_us_nxt == 16'(COOLDOWN_US)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pre   <= '0;
            r_us    <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_echo  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_echo     = r_echo;
  assign bus.o_busy     = r_busy;
  assign bus.o_trig_cnt = r_cnt;
endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Bench for sr04_echo_emulator with shrunk timing
// parameters; echoes are checked against a queue.
module tb_sr04_echo_emulator;
  localparam int D     = 4;
  localparam int TMIN  = 10;
  localparam int DLY   = 20;
  localparam int UPC   = 3;
  localparam int MAXC  = 400;
  localparam int TOUT  = 1500;
  localparam int COOL  = 50;
  localparam int BOUND = 20000;

  typedef struct {
    int         w;
    logic [8:0] d;
    bit         acc;
  } vec_t;

  typedef struct {
    int rise;
    int len;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  int   fall_cyc;
  logic [7:0] m_cnt;
  exp_t exp_q[$];
  exp_t cur;
  bit   m_prev;
  bit   m_act;
  int   m_rise;
  vec_t vt[8];

  sr04_echo_emulator_if bus();

  sr04_echo_emulator #(
    .CLK_DIV       (D),
    .TRIG_MIN_US   (TMIN),
    .ECHO_DELAY_US (DLY),
    .US_PER_CM     (UPC),
    .MAX_CM        (MAXC),
    .TIMEOUT_US    (TOUT),
    .COOLDOWN_US   (COOL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int model_len(logic [8:0] d);
    if (d == 9'd0 || int'(d) > MAXC) return TOUT;
    return int'(d) * UPC;
  endfunction

  // scoreboard monitor: pops one record per echo pulse
  always @(negedge clk) begin
    if (rst) begin
      m_prev = 1'b0;
      m_act  = 1'b0;
    end else begin
      if (bus.o_echo && !m_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_echo", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("echo_rise_cyc", cyc, cur.rise);
          m_rise = cyc;
          m_act  = 1'b1;
        end
      end else if (!bus.o_echo && m_prev && m_act) begin
        check("echo_width", cyc - m_rise, cur.len);
        m_act = 1'b0;
      end
      m_prev = bus.o_echo;
    end
  end

  task automatic pulse(int w);
    @(negedge clk);
    bus.i_trigger = 1'b1;
    repeat (w) @(negedge clk);
    bus.i_trigger = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic push_exp(logic [8:0] d);
    exp_t e;
    e.rise = fall_cyc + 3 + DLY * D;
    e.len  = model_len(d) * D;
    exp_q.push_back(e);
    m_cnt = m_cnt + 8'd1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_echo(bit v);
    int n;
    n = 0;
    while (bus.o_echo != v && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("echo_timeout", 0, 1);
  endtask

  task automatic run_trig(int w, logic [8:0] d, bit acc);
    bus.i_dist_cm = d;
    pulse(w);
    if (acc) push_exp(d);
    repeat (2) @(negedge clk);
    check("busy_hold", int'(bus.o_busy), 1);
    @(negedge clk);
    check("busy_after_fall", int'(bus.o_busy), int'(acc));
    wait_idle();
    check("trig_cnt", int'(bus.o_trig_cnt), int'(m_cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_cnt  = 8'd0;
    m_prev = 1'b0;
    m_act  = 1'b0;
    rst    = 1'b1;
    bus.i_trigger = 1'b0;
    bus.i_dist_cm = 9'd0;

    vt[0] = '{w: 10*D,   d: 9'd10,  acc: 1'b1};
    vt[1] = '{w: 5*D,    d: 9'd10,  acc: 1'b0};
    vt[2] = '{w: 10*D-1, d: 9'd10,  acc: 1'b0};
    vt[3] = '{w: 10*D,   d: 9'd0,   acc: 1'b1};
    vt[4] = '{w: 10*D,   d: 9'd401, acc: 1'b1};
    vt[5] = '{w: 10*D,   d: 9'd400, acc: 1'b1};
    vt[6] = '{w: 10*D,   d: 9'd1,   acc: 1'b1};
    vt[7] = '{w: 30*D,   d: 9'd511, acc: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_echo", int'(bus.o_echo), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_cnt", int'(bus.o_trig_cnt), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_trig(vt[i].w, vt[i].d, vt[i].acc);
    end

    // distance change during burst has no effect
    bus.i_dist_cm = 9'd400;
    pulse(10*D);
    push_exp(9'd400);
    repeat (10) @(negedge clk);
    bus.i_dist_cm = 9'd5;
    wait_idle();
    check("cnt_dist_chg", int'(bus.o_trig_cnt),
          int'(m_cnt));

    // triggers during echo and cooldown are ignored
    bus.i_dist_cm = 9'd20;
    pulse(10*D);
    push_exp(9'd20);
    wait_echo(1'b1);
    pulse(10*D);
    wait_echo(1'b0);
    repeat (5) @(negedge clk);
    pulse(10*D);
    wait_idle();
    check("cnt_ignored", int'(bus.o_trig_cnt),
          int'(m_cnt));

    // trigger held high across entry to idle
    bus.i_dist_cm = 9'd1;
    pulse(10*D);
    push_exp(9'd1);
    wait_echo(1'b1);
    wait_echo(1'b0);
    @(negedge clk);
    bus.i_trigger = 1'b1;
    wait_idle();
    repeat (20) @(negedge clk);
    bus.i_trigger = 1'b0;
    repeat (10) @(negedge clk);
    check("held_busy", int'(bus.o_busy), 0);
    check("held_cnt", int'(bus.o_trig_cnt),
          int'(m_cnt));

    run_trig(10*D, 9'd7, 1'b1);

    // asynchronous reset in the middle of an echo
    bus.i_dist_cm = 9'd100;
    pulse(10*D);
    push_exp(9'd100);
    wait_echo(1'b1);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_echo", int'(bus.o_echo), 0);
    check("arst_busy", int'(bus.o_busy), 0);
    check("arst_cnt", int'(bus.o_trig_cnt), 0);
    exp_q.delete();
    m_cnt = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_trig(10*D, 9'd100, 1'b1);

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
